uart_byte_tx: RTL

UART_BYTE_TX -- requirements
Module: uart_byte_tx

---
 rtl/uart_byte_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_byte_tx.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
module uart_byte_tx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_go,
    input  logic [7:0] data,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BP    = CLOCK_FREQ / BAUD;
    localparam int CNT_W = (BP > 1) ? $clog2(BP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BP - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`else
    // Parity sense only matters when the parity bit is built in.
    localparam bit unused_parity_odd = PARITY_ODD;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             baud_wrap;

    assign baud_wrap = (baud_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send_go) begin
                    state_d = S_START;
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data) ^ PARITY_ODD;
`endif
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE with done set lets a send_go in that cycle start the next frame.
                if (baud_wrap) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign uart_tx = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
